// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg
//   Shared types for the iterative ALU: the 3-bit operation encoding
//   carried on ALUControl, the controller state encoding, and a small
//   helper that classifies the divide-family operations.
//   Optional feature macro: ALU_ITER_DIV_EN (see alu_iter.sv).
package alu_iter_pkg;

    // Operation encoding as it appears on the ALUControl port
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    // Controller states: accept a request, iterate, present the result
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // True for the two operations that share the divider datapath
    function automatic logic isDivOp(alu_op_e op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_iter_divider.sv
// alu_iter_divider
//   Unsigned restoring divider, one quotient bit per clock, WIDTH steps.
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous active-high reset, aborts any division
//     start_i      load dividend/divisor and begin (ignored-free: always loads)
//     dividend_i   WIDTH-bit dividend
//     divisor_i    WIDTH-bit divisor
//     done_o       high during the cycle whose closing edge performs the
//                  final step; quotient_o/remainder_o are the values that
//                  step produces, so the parent can register them on that edge
//     quotient_o   final quotient (valid with done_o)
//     remainder_o  final remainder (valid with done_o)
//   A zero divisor needs no special casing: every trial subtraction
//   succeeds, giving an all-ones quotient, and the remainder register just
//   accumulates the dividend bits, ending equal to the dividend.
module alu_iter_divider #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trialLow;
    logic             fits;
    logic [WIDTH-1:0] remStep;
    logic [WIDTH-1:0] quotStep;

    // One restoring step: bring the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. When it fits the
    // difference is below 2^WIDTH, so the low bits of a WIDTH-bit
    // subtraction are already the exact new remainder.
    always_comb begin
        shifted  = {rem_q, quot_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvsr_q});
        trialLow = shifted[WIDTH-1:0] - dvsr_q;
        remStep  = fits ? trialLow : shifted[WIDTH-1:0];
        quotStep = {quot_q[WIDTH-2:0], fits};
    end

    assign done_o      = busy_q && (cnt_q == CNT_LAST);
    assign quotient_o  = quotStep;
    assign remainder_o = remStep;

    // Next-state: a start reloads the operands; otherwise a busy divider
    // takes one step per cycle and stops itself after the last one.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quot_d = dividend_i;
            rem_d  = '0;
            dvsr_d = divisor_i;
        end else if (busy_q) begin
            quot_d = quotStep;
            rem_d  = remStep;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset so a parent reset aborts
    // a division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter
//   Multi-cycle ALU. ADD/SUB/AND/OR/XOR finish one cycle after start;
//   MUL (shift-add) and DIV/MOD (restoring divider) iterate WIDTH cycles
//   and finish WIDTH+1 cycles after start.
//   Feature macro ALU_ITER_DIV_EN: when defined the divider sub-module is
//   built; when undefined DIV/MOD finish in one cycle with Result=0,
//   OverFlow=1 (illegal-op marker) and DivZero=0.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     start       request, only looked at in IDLE
//     A, B        WIDTH-bit operands, captured on an accepted start
//     ALUControl  3-bit operation (see alu_iter_pkg::alu_op_e)
//     busy        high while iterating
//     done        one-cycle pulse, Result and flags are fresh
//     Result      registered result, held until the next done
//     Zero, OverFlow, Negative, DivZero  registered flags
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             OverFlow,
    output logic             Negative,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int MSB = WIDTH - 1;

    state_e             state_q, state_d;
    alu_op_e            op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               neg_q, neg_d;
    logic               divz_q, divz_d;

    alu_op_e            opIn;
    logic [WIDTH-1:0]   sumAB;
    logic [WIDTH-1:0]   diffAB;
    logic [WIDTH:0]     mulAdd;
    logic [2*WIDTH-1:0] prodStep;

    logic               finish;
    logic [WIDTH-1:0]   finRes;
    logic               finOvf;
    logic               finDz;

    assign opIn   = alu_op_e'(ALUControl);
    assign sumAB  = A + B;
    assign diffAB = A - B;

    // Shift-add multiply step: the upper half of prod_q is the running
    // partial sum, the lower half starts as the multiplier and is consumed
    // one bit per step from the LSB end. Adding the multiplicand and
    // shifting the whole (WIDTH+1)+(WIDTH-1) bit vector right keeps the
    // carry, so after WIDTH steps prod_q holds the full 2*WIDTH product.
    assign mulAdd   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign prodStep = {mulAdd, prod_q[WIDTH-1:1]};

`ifdef ALU_ITER_DIV_EN
    logic             bZero_q, bZero_d;
    logic             divStart;
    logic             divDone;
    logic [WIDTH-1:0] divQuot;
    logic [WIDTH-1:0] divRem;

    // The divider captures A/B itself on the same edge the controller
    // accepts the request, so both start iterating together.
    assign divStart = (state_q == S_IDLE) && start && isDivOp(opIn);

    alu_iter_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk         (clk),
        .rst         (rst),
        .start_i     (divStart),
        .dividend_i  (A),
        .divisor_i   (B),
        .done_o      (divDone),
        .quotient_o  (divQuot),
        .remainder_o (divRem)
    );
`endif

    // Controller next-state. Single-cycle ops compute straight from the
    // inputs on the accepting edge and jump to DONE; iterative ops capture
    // their operands and sit in RUN. Whatever path finishes raises
    // 'finish', and the block at the bottom loads Result and all flags
    // together so they can only ever change on the edge entering DONE.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        divz_d   = divz_q;
`ifdef ALU_ITER_DIV_EN
        bZero_d  = bZero_q;
`endif
        finish   = 1'b0;
        finRes   = '0;
        finOvf   = 1'b0;
        finDz    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = opIn;
                    case (opIn)
                        OP_ADD: begin
                            finish = 1'b1;
                            finRes = sumAB;
                            finOvf = (A[MSB] == B[MSB]) && (sumAB[MSB] != A[MSB]);
                        end
                        OP_SUB: begin
                            finish = 1'b1;
                            finRes = diffAB;
                            finOvf = (A[MSB] != B[MSB]) && (diffAB[MSB] != A[MSB]);
                        end
                        OP_AND: begin
                            finish = 1'b1;
                            finRes = A & B;
                        end
                        OP_OR: begin
                            finish = 1'b1;
                            finRes = A | B;
                        end
                        OP_XOR: begin
                            finish = 1'b1;
                            finRes = A ^ B;
                        end
                        OP_MUL: begin
                            state_d = S_RUN;
                            cnt_d   = '0;
                            mcand_d = B;
                            prod_d  = {{WIDTH{1'b0}}, A};
                        end
                        OP_DIV, OP_MOD: begin
`ifdef ALU_ITER_DIV_EN
                            state_d = S_RUN;
                            bZero_d = (B == '0);
`else
                            finish  = 1'b1;
                            finRes  = '0;
                            finOvf  = 1'b1;
`endif
                        end
                        default: begin
                        end
                    endcase
                end
            end

            S_RUN: begin
`ifdef ALU_ITER_DIV_EN
                if (isDivOp(op_q)) begin
                    if (divDone) begin
                        finish = 1'b1;
                        finRes = (op_q == OP_DIV) ? divQuot : divRem;
                        finDz  = bZero_q;
                    end
                end else
`endif
                begin
                    prod_d = prodStep;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        finish = 1'b1;
                        finRes = prodStep[WIDTH-1:0];
                        finOvf = |prodStep[2*WIDTH-1:WIDTH];
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d  = S_DONE;
            result_d = finRes;
            zero_d   = (finRes == '0);
            neg_d    = finRes[MSB];
            ovf_d    = finOvf;
            divz_d   = finDz;
        end
    end

    // State and result registers. Reset clears everything, which also
    // throws away any operation in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            divz_q   <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            bZero_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            divz_q   <= divz_d;
`ifdef ALU_ITER_DIV_EN
            bZero_q  <= bZero_d;
`endif
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign OverFlow = ovf_q;
    assign Negative = neg_q;
    assign DivZero  = divz_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter
//   Scoreboard bench for alu_iter at WIDTH=19. Stimulus pushes the
//   expected response (from an arithmetic reference model) into a queue;
//   a monitor pops and compares on every done pulse, and between pulses
//   checks that Result holds. Follows ALU_ITER_DIV_EN like the design.
module tb_alu_iter;

    localparam int W = 19;
    localparam longint unsigned FULL = 64'd1 << W;
    localparam longint unsigned MASK = FULL - 64'd1;
    localparam longint unsigned HALF = 64'd1 << (W - 1);
    localparam longint SMAX = longint'(HALF) - 1;
    localparam longint SMIN = -longint'(HALF);

    typedef struct {
        logic [W-1:0] res;
        bit           zero;
        bit           ovf;
        bit           neg;
        bit           dz;
        int           lat;
        int           busyCycles;
        longint       startCyc;
    } expT;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] aIn;
    logic [W-1:0] bIn;
    logic [2:0]   aluCtl;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         Zero;
    logic         OverFlow;
    logic         Negative;
    logic         DivZero;

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;
    expT    expQ[$];

    alu_iter #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (aIn),
        .B          (bIn),
        .ALUControl (aluCtl),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .Zero       (Zero),
        .OverFlow   (OverFlow),
        .Negative   (Negative),
        .DivZero    (DivZero)
    );

    // Free-running clock and a cycle counter used to measure latency
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: counts it, and reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic longint toSigned(input longint unsigned v);
        return (v >= HALF) ? longint'(v) - longint'(FULL) : longint'(v);
    endfunction

    // Reference model written from the arithmetic definition of each op
    function automatic expT model(input int op, input longint unsigned a, input longint unsigned b);
        expT             e;
        longint unsigned r;
        longint unsigned p;
        longint          st;
        e.ovf        = 1'b0;
        e.dz         = 1'b0;
        e.lat        = 1;
        e.busyCycles = 0;
        e.startCyc   = 0;
        r            = 0;
        case (op)
            0: begin
                r     = (a + b) & MASK;
                st    = toSigned(a) + toSigned(b);
                e.ovf = (st > SMAX) || (st < SMIN);
            end
            1: begin
                r     = (a - b) & MASK;
                st    = toSigned(a) - toSigned(b);
                e.ovf = (st > SMAX) || (st < SMIN);
            end
            2: begin
                p            = a * b;
                r            = p & MASK;
                e.ovf        = (p >> W) != 0;
                e.lat        = W + 1;
                e.busyCycles = W;
            end
            3, 4: begin
`ifdef ALU_ITER_DIV_EN
                if (b == 0) begin
                    r    = (op == 3) ? MASK : a;
                    e.dz = 1'b1;
                end else begin
                    r = (op == 3) ? a / b : a % b;
                end
                e.lat        = W + 1;
                e.busyCycles = W;
`else
                r     = 0;
                e.ovf = 1'b1;
`endif
            end
            5: r = a & b;
            6: r = a | b;
            default: r = a ^ b;
        endcase
        e.res  = r[W-1:0];
        e.zero = (r == 0);
        e.neg  = ((r >> (W - 1)) & 1) != 0;
        return e;
    endfunction

    // Monitor: compare each done pulse against the oldest expectation,
    // and check Result holds in every other cycle.
    logic [W-1:0] heldRes  = '0;
    int           busyRun  = 0;
    expT          monE;

    always @(negedge clk) begin
        if (rst) begin
            heldRes = '0;
            busyRun = 0;
        end else begin
            if (busy) busyRun++;
            if (done) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("Result",   Result,   monE.res);
                    checkOutput("Zero",     Zero,     monE.zero);
                    checkOutput("OverFlow", OverFlow, monE.ovf);
                    checkOutput("Negative", Negative, monE.neg);
                    checkOutput("DivZero",  DivZero,  monE.dz);
                    checkOutput("latency",  cyc - monE.startCyc, monE.lat);
                    checkOutput("busyCycles", busyRun, monE.busyCycles);
                end
                heldRes = Result;
                busyRun = 0;
            end else begin
                checkOutput("holdResult", Result, heldRes);
            end
        end
    end

    // Drive one request for a single cycle; called just after a rising edge
    task automatic issue(input int op, input longint unsigned a, input longint unsigned b);
        expT e;
        aIn    = a[W-1:0];
        bIn    = b[W-1:0];
        aluCtl = op[2:0];
        start  = 1'b1;
        e          = model(op, a, b);
        e.startCyc = cyc;
        expQ.push_back(e);
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    // Wait (bounded) until the monitor has consumed every expectation
    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk) #1;
            n++;
        end
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout: got %0d pending, expected 0 pending", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic applyStimulus(input int op, input longint unsigned a, input longint unsigned b);
        issue(op, a, b);
        waitDrain();
    endtask

    function automatic longint unsigned randOperand();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return MASK;
            2:       return HALF;
            3:       return longint'($urandom_range(0, 31));
            default: return longint'($urandom) & MASK;
        endcase
    endfunction

    initial begin
        int           abortOp;
        longint unsigned ra, rb;

        rst    = 1'b1;
        start  = 1'b0;
        aIn    = '0;
        bIn    = '0;
        aluCtl = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("reset_busy",     busy,     0);
        checkOutput("reset_done",     done,     0);
        checkOutput("reset_Result",   Result,   0);
        checkOutput("reset_Zero",     Zero,     0);
        checkOutput("reset_OverFlow", OverFlow, 0);
        checkOutput("reset_Negative", Negative, 0);
        checkOutput("reset_DivZero",  DivZero,  0);

        // Directed cases, issued back to back
        applyStimulus(0, 25, 5);
        applyStimulus(2, 25, 5);
        applyStimulus(2, 64'h7FFFF, 2);
        applyStimulus(3, 26, 5);
        applyStimulus(4, 26, 5);
        applyStimulus(3, 10, 0);
        applyStimulus(4, 10, 0);
        applyStimulus(0, 64'h3FFFF, 1);
        applyStimulus(1, 5, 5);
        applyStimulus(1, 0, 1);
        applyStimulus(5, 64'h5A5A5, 64'h0FF0F);
        applyStimulus(6, 64'h40000, 64'h00001);
        applyStimulus(7, 64'h7FFFF, 64'h7FFFF);

        // A start with new operands during a multiply must be ignored
        issue(2, 25, 5);
        repeat (5) @(posedge clk) #1;
        aIn    = 7;
        bIn    = 9;
        aluCtl = 3'b000;
        start  = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        waitDrain();

        // Reset ten cycles into a long op, together with a fresh start
`ifdef ALU_ITER_DIV_EN
        abortOp = 3;
`else
        abortOp = 2;
`endif
        issue(abortOp, 26, 5);
        repeat (9) @(posedge clk) #1;
        expQ.delete();
        rst    = 1'b1;
        aIn    = 1;
        bIn    = 1;
        aluCtl = 3'b000;
        start  = 1'b1;
        @(posedge clk) #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk) #1;
        checkOutput("abort_busy",     busy,     0);
        checkOutput("abort_done",     done,     0);
        checkOutput("abort_Result",   Result,   0);
        checkOutput("abort_OverFlow", OverFlow, 0);
        applyStimulus(3, 26, 5);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ra = randOperand();
            rb = randOperand();
            applyStimulus(int'($urandom_range(0, 7)), ra, rb);
        end

        repeat (3) @(posedge clk) #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 19, operand/result width in bits (min 4).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have ports A, B  input  WIDTH  operands, latched on accepted start.
REQ-006 SHALL have port ALUControl  input  3  op: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 AND, 110 OR, 111 XOR; latched with operands.
REQ-007 SHALL have port busy  output  1  high in RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port Result  output  WIDTH  registered result.
REQ-010 SHALL have ports Zero, OverFlow, Negative, DivZero  output  1 each  registered flags.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; start in IDLE latches A, B, ALUControl.
REQ-012 ADD/SUB/AND/OR/XOR SHALL go IDLE -> DONE; done high the cycle after start (latency 1).
REQ-013 MUL/DIV/MOD SHALL run WIDTH iterations in RUN; done high exactly WIDTH+1 cycles after start.
REQ-014 MUL SHALL be unsigned shift-add; Result = low WIDTH bits; OverFlow = 1 iff upper WIDTH bits nonzero.
REQ-015 DIV/MOD SHALL be unsigned restoring division; DIV gives quotient, MOD remainder.
REQ-016 B = 0 on DIV/MOD: DivZero=1, DIV Result = all ones, MOD Result = A; latency unchanged.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; OverFlow = signed two's-complement overflow.
REQ-018 Logic ops SHALL clear OverFlow; DivZero SHALL be 0 on all non-DIV/MOD ops.
REQ-019 Zero = (Result == 0); Negative = Result[WIDTH-1]; all flags update with Result in DONE.
REQ-020 Result and flags SHALL hold from done until the next done; not updated in RUN.
REQ-021 start while busy or done high SHALL be ignored, no queuing; operand changes in RUN SHALL not affect result.
REQ-022 start in the cycle after done (IDLE) SHALL be accepted; back-to-back ops allowed.

Reset
REQ-023 rst SHALL force IDLE, busy=0, done=0, Result=0, all flags=0 on next edge.
REQ-024 rst mid-RUN SHALL abort; no done pulse for aborted op; rst wins over simultaneous start.

Configuration
REQ-025 Macro ALU_ITER_DIV_EN defined: DIV/MOD per REQ-013..016.
REQ-026 ALU_ITER_DIV_EN undefined: no divider hardware; DIV/MOD complete with latency 1, Result=0, DivZero=0, OverFlow=1 as illegal-op marker.

Structure
REQ-027 Package alu_iter_pkg SHALL hold the op enum (3-bit encodings above) and FSM state enum.
REQ-028 Division SHALL be sub-module alu_iter_divider (WIDTH param, start/done, quotient/remainder), instantiated only under ALU_ITER_DIV_EN.
REQ-029 MUL iteration SHALL stay in alu_iter; no combinational multiplier or divider.

Verification (WIDTH=19)
REQ-030 ADD A=25, B=5 -> Result=30, done 1 cycle after start, flags 0.
REQ-031 MUL A=25, B=5 -> Result=125, done 20 cycles after start, busy high 19 cycles, OverFlow=0; MUL 0x7FFFF*2 -> OverFlow=1.
REQ-032 DIV 26/5 -> 5; MOD 26/5 -> 1; DIV 10/0 -> 0x7FFFF, DivZero=1; MOD 10/0 -> 10.
REQ-033 ADD 0x3FFFF+1 -> 0x40000, OverFlow=1, Negative=1; SUB 5-5 -> 0, Zero=1.
REQ-034 start pulsed during MUL RUN with new operands -> ignored, original result; rst at cycle 10 of DIV -> no done, outputs 0, next op correct.
REQ-035 Build without ALU_ITER_DIV_EN: DIV 26/5 -> Result=0, OverFlow=1, done 1 cycle after start.
